// File: rtl/bus_fabric.sv
`default_nettype none
// ============================================================================
// Module   : bus_fabric
// Brief    : Resolves SOURCES active-low-enabled drivers onto one shared bus,
//            with bus keeper, contention tracking and a FWFT debug trace FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module bus_fabric #(
    parameter int WIDTH       = 8,
    parameter int SOURCES     = 4,
    parameter int TRACE_DEPTH = 16,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                              i_clk,
    input  logic                              i_reset,
    input  logic [SOURCES*WIDTH-1:0]          i_data,
    input  logic [SOURCES-1:0]                i_noe,
    output logic [WIDTH-1:0]                  o_data,
    output logic                              o_contention,
    output logic                              o_errSticky,
    input  logic                              i_errClear,
    output logic [CNT_WIDTH-1:0]              o_contentionCount,
    input  logic                              i_traceEnable,
    input  logic                              i_tracePop,
    output logic [WIDTH+$clog2(SOURCES)-1:0]  o_traceData,
    output logic                              o_traceValid,
    output logic [$clog2(TRACE_DEPTH):0]      o_traceLevel,
    output logic                              o_traceOverflow
);

    localparam int SID_W = $clog2(SOURCES);
    localparam int PTR_W = $clog2(TRACE_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int ENT_W = WIDTH + SID_W;
    localparam logic [LVL_W-1:0]     FULL_LEVEL = LVL_W'(TRACE_DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;

    logic [SOURCES-1:0] enabled;
    logic               active;
    logic [SID_W-1:0]   winner_id;
    logic [WIDTH-1:0]   win_data;
    logic [WIDTH-1:0]   keeper;

    assign enabled = ~i_noe;
    assign active  = |enabled;

    // Descending scan so the lowest-index enabled source is the last to assign.
    always_comb begin
        winner_id = '0;
        win_data  = '0;
        for (int k = SOURCES - 1; k >= 0; k--) begin
            if (enabled[k]) begin
                winner_id = SID_W'(k);
                win_data  = i_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // More than one bit set <=> clearing the lowest set bit leaves something.
    assign o_contention = |(enabled & (enabled - SOURCES'(1)));
    assign o_data       = active ? win_data : keeper;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            keeper <= '0;
        end else if (active) begin
            keeper <= o_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_errSticky       <= 1'b0;
            o_contentionCount <= '0;
        end else begin
            if (o_contention) begin
                o_errSticky <= 1'b1;
            end else if (i_errClear) begin
                o_errSticky <= 1'b0;
            end

            if (o_contention) begin
                if (i_errClear) begin
                    o_contentionCount <= CNT_WIDTH'(1);
                end else if (o_contentionCount != CNT_MAX) begin
                    o_contentionCount <= o_contentionCount + CNT_WIDTH'(1);
                end
            end else if (i_errClear) begin
                o_contentionCount <= '0;
            end
        end
    end

    logic [ENT_W-1:0] trace_mem [TRACE_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level;
    logic             full;
    logic             push_req;
    logic             pop_ok;
    logic             push_ok;
    logic             drop;

    assign full     = (level == FULL_LEVEL);
    assign push_req = i_traceEnable & active;
    assign pop_ok   = i_tracePop & (level != '0);
    // A pop frees the slot in the same cycle, so a full FIFO can still accept.
    assign push_ok  = push_req & (~full | pop_ok);
    assign drop     = push_req & full & ~pop_ok;

    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            trace_mem[wr_ptr] <= {winner_id, o_data};
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            level           <= '0;
            o_traceOverflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
            if (drop) begin
                o_traceOverflow <= 1'b1;
            end else if (i_errClear) begin
                o_traceOverflow <= 1'b0;
            end
        end
    end

    assign o_traceData  = trace_mem[rd_ptr];
    assign o_traceValid = (level != '0);
    assign o_traceLevel = level;

endmodule
`default_nettype wire
